// File: rtl/dadda_8_if.sv
// rtl/dadda_8_if.sv - operand/product bus for the dadda_8 multiplier
interface dadda_8_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        valid_in;
    logic [15:0] y;
    logic        valid_out;

    modport master (
        output A,
        output B,
        output valid_in,
        input  y,
        input  valid_out
    );

    modport slave (
        input  A,
        input  B,
        input  valid_in,
        output y,
        output valid_out
    );
endinterface

// File: rtl/dadda_8.sv
// rtl/dadda_8.sv - 8x8 unsigned Dadda-tree multiplier with registered product
// Optional input register stage (latency 2 instead of 1): define DADDA_8_INPUT_REG_EN.
module dadda_8 (
    input  logic     clk,
    input  logic     rst_n,
    dadda_8_if.slave bus
);

    // Builds the 64 partial products, then reduces columns through heights
    // 6, 4, 3, 2. Each column adds the fewest full/half adders needed to reach
    // the stage target, counting carries already pushed in from the column below.
    // All loop bounds and heights are data-independent, so the loops unroll into
    // a fixed adder netlist. Returns {row1, row0} for the final carry-propagate add.
    function automatic logic [29:0] dadda_rows(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] cur [16];
        logic [15:0] nxt [16];
        int          h   [16];
        int          nh  [16];
        int          dt  [4];
        logic [14:0] r0;
        logic [14:0] r1;
        dt = '{6, 4, 3, 2};
        for (int c = 0; c < 16; c++) begin
            cur[c] = '0;
            nxt[c] = '0;
            h[c]   = 0;
            nh[c]  = 0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                int c;
                int p;
                c = i + j;
                p = h[c[3:0]];
                cur[c[3:0]][p[3:0]] = a[i[2:0]] & b[j[2:0]];
                h[c[3:0]] = p + 1;
            end
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 16; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int c = 0; c < 16; c++) begin
                int idx;
                int rem;
                int cn;
                idx = 0;
                rem = h[c[3:0]];
                cn  = (c < 15) ? c + 1 : 15;
                for (int k = 0; k < 4; k++) begin
                    int   tot;
                    int   o;
                    int   i1;
                    int   i2;
                    logic x0;
                    logic x1;
                    logic x2;
                    logic half;
                    tot = rem + nh[c[3:0]];
                    if (tot > dt[s[1:0]]) begin
                        // one excess bit needs only a half adder; more needs a full adder
                        half = (tot - dt[s[1:0]] == 1);
                        i1   = idx + 1;
                        i2   = idx + 2;
                        x0   = cur[c[3:0]][idx[3:0]];
                        x1   = cur[c[3:0]][i1[3:0]];
                        x2   = half ? 1'b0 : cur[c[3:0]][i2[3:0]];
                        o    = nh[c[3:0]];
                        nxt[c[3:0]][o[3:0]] = x0 ^ x1 ^ x2;
                        nh[c[3:0]] = o + 1;
                        if (c < 15) begin
                            o = nh[cn[3:0]];
                            nxt[cn[3:0]][o[3:0]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                            nh[cn[3:0]] = o + 1;
                        end
                        idx = half ? idx + 2 : idx + 3;
                        rem = half ? rem - 2 : rem - 3;
                    end
                end
                // untouched bits pass straight through to the next stage
                for (int k = 0; k < 16; k++) begin
                    int o;
                    int t;
                    if (k < rem) begin
                        t = idx + k;
                        o = nh[c[3:0]];
                        nxt[c[3:0]][o[3:0]] = cur[c[3:0]][t[3:0]];
                        nh[c[3:0]] = o + 1;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                cur[c] = nxt[c];
                h[c]   = nh[c];
            end
        end
        for (int c = 0; c < 15; c++) begin
            r0[c] = cur[c][0];
            r1[c] = cur[c][1];
        end
        return {r1, r0};
    endfunction

    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_v;
    logic [14:0] row0;
    logic [14:0] row1;
    logic [15:0] prod;
    logic [15:0] y_d;
    logic [15:0] y_q;
    logic        valid_out_d;
    logic        valid_out_q;

`ifdef DADDA_8_INPUT_REG_EN
    logic [7:0] a_d;
    logic [7:0] a_q;
    logic [7:0] b_d;
    logic [7:0] b_q;
    logic       vin_d;
    logic       vin_q;

    // input stage captures every cycle; the registered valid drives the output hold rule
    always_comb begin
        a_d   = bus.A;
        b_d   = bus.B;
        vin_d = bus.valid_in;
    end

    // input registers, cleared by reset so nothing in flight survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            vin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vin_q <= vin_d;
        end
    end

    assign mul_a = a_q;
    assign mul_b = b_q;
    assign mul_v = vin_q;
`else
    assign mul_a = bus.A;
    assign mul_b = bus.B;
    assign mul_v = bus.valid_in;
`endif

    // partial products and Dadda reduction down to two rows
    always_comb begin
        {row1, row0} = dadda_rows(mul_a, mul_b);
    end

    // ripple-carry final adder; its carry-out is product bit 15
    always_comb begin
        logic carry;
        carry = 1'b0;
        prod  = '0;
        for (int i = 0; i < 15; i++) begin
            prod[i] = row0[i] ^ row1[i] ^ carry;
            carry   = (row0[i] & row1[i]) | (carry & (row0[i] ^ row1[i]));
        end
        prod[15] = carry;
    end

    // load a new product on an accepted pair, otherwise hold; valid pulses per pair
    always_comb begin
        y_d         = mul_v ? prod : y_q;
        valid_out_d = mul_v;
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            valid_out_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_dadda_8.sv
// tb/tb_dadda_8.sv - scoreboard testbench for dadda_8
module tb_dadda_8;

`ifdef DADDA_8_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   passed;
    exp_t sb_q[$];
    logic [15:0] last_y;

    dadda_8_if bus ();

    dadda_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not finish, pending=%0d want 0", sb_q.size());
        $fatal(1);
    end

    task automatic check(input string name, input logic ok, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic v, input logic [15:0] exp_y);
        exp_t e;
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.valid_in = v;
        if (v) begin
            e.y   = exp_y;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        return {8'h00, a} * {8'h00, b};
    endfunction

    // monitor: pops on every valid_out, checks value and latency; checks hold otherwise
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_y = 16'h0000;
            end else if (bus.valid_out) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid_out", 1'b0, {16'h0, bus.y}, 32'h0);
                end else begin
                    e   = sb_q.pop_front();
                    lat = cyc - e.cyc;
                    check("product", (bus.y === e.y) && (lat == LAT),
                          {lat[15:0], bus.y}, {LAT[15:0], e.y});
                end
                last_y = bus.y;
            end else begin
                check("hold", bus.y === last_y, {16'h0, bus.y}, {16'h0, last_y});
            end
        end
    end

    initial begin
        cyc          = 0;
        checks       = 0;
        passed       = 0;
        last_y       = 16'h0000;
        bus.A        = 8'h00;
        bus.B        = 8'h00;
        bus.valid_in = 1'b0;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("reset_y", bus.y === 16'h0000, {16'h0, bus.y}, 32'h0);
        check("reset_valid", bus.valid_out === 1'b0, {31'h0, bus.valid_out}, 32'h0);
        repeat (3) @(negedge clk);
        check("reset_held_y", bus.y === 16'h0000, {16'h0, bus.y}, 32'h0);
        rst_n = 1'b1;

        // directed boundary vectors
        issue(8'hFF, 8'hFF, 1'b1, 16'hFE01);
        issue(8'h00, 8'hA5, 1'b1, 16'h0000);
        issue(8'h80, 8'h02, 1'b1, 16'h0100);
        issue(8'h01, 8'h37, 1'b1, 16'h0037);
        issue(8'hA5, 8'h00, 1'b1, 16'h0000);
        issue(8'h37, 8'h01, 1'b1, 16'h0037);
        issue(8'h0C, 8'h0D, 1'b1, 16'h009C);
        issue(8'h33, 8'h44, 1'b0, 16'h0000);
        issue(8'h55, 8'h66, 1'b0, 16'h0000);
        issue(8'h77, 8'h88, 1'b0, 16'h0000);

        // asynchronous reset mid-cycle with a nonzero product held
        issue(8'hFF, 8'hFF, 1'b1, 16'hFE01);
        repeat (LAT + 1) issue(8'h00, 8'h00, 1'b0, 16'h0000);
        #3;
        check("pre_reset_nonzero", bus.y === 16'hFE01, {16'h0, bus.y}, 32'h0000FE01);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_reset_y", bus.y === 16'h0000, {16'h0, bus.y}, 32'h0);
        check("async_reset_valid", bus.valid_out === 1'b0, {31'h0, bus.valid_out}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset shortly after accepting a pair discards it
        issue(8'h12, 8'h34, 1'b1, 16'h03A8);
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) issue(8'h12, 8'h34, 1'b0, 16'h0000);
        issue(8'h12, 8'h34, 1'b1, 16'h03A8);
        issue(8'h00, 8'h00, 1'b0, 16'h0000);

        // random pairs back-to-back
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            issue(a, b, 1'b1, model(a, b));
        end

        // every operand pair, one per cycle
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v = i[15:0];
            issue(v[15:8], v[7:0], 1'b1, model(v[15:8], v[7:0]));
        end
        repeat (LAT + 3) issue(8'h00, 8'h00, 1'b0, 16'h0000);

        check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
